instruction_fetch: RTL

//  Fetch stage of the SLURM core. Drives the synchronous program ROM (registered read, 1-cycle latency) and buffers returned words.

---
 rtl/instruction_fetch.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage of the SLURM core. Drives a synchronous program ROM
//   (registered read, one cycle of latency). Returned words go into a
//   two-entry queue that feeds decode over a valid/ready handshake.
//   The stage also handles branch redirect, halt, and back-pressure from decode.
//
// Parameters
//   BITS          instruction word width
//   ADDRESS_BITS  program counter / ROM address width
//   RESET_VECTOR  first fetch address after reset
//
// Ports
//   CLK            core clock
//   RSTb           asynchronous active-low reset
//   ROM_ADDRESS    ROM address (combinational: branch target or PC)
//   ROM_DATA       ROM read data, valid the cycle after ROM_ADDRESS
//   HALT           stop issuing new fetches
//   BRANCH_VALID   one-cycle redirect strobe
//   BRANCH_TARGET  redirect address
//   INSTR          instruction at queue head
//   INSTR_PC       address of INSTR
//   INSTR_VALID    queue non-empty
//   INSTR_READY    decode accepts INSTR this cycle
//   FETCH_COUNT    (IFETCH_STATS_EN only) accepted-word counter, wraps at 0xFFFF
//
// Build option
//   IFETCH_STATS_EN  adds the FETCH_COUNT port and its counter.
module instruction_fetch #(
  parameter int          BITS         = 16,
  parameter int          ADDRESS_BITS = 8,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  output logic [ADDRESS_BITS-1:0] ROM_ADDRESS,
  input  logic [BITS-1:0]         ROM_DATA,
  input  logic                    HALT,
  input  logic                    BRANCH_VALID,
  input  logic [ADDRESS_BITS-1:0] BRANCH_TARGET,
  output logic [BITS-1:0]         INSTR,
  output logic [ADDRESS_BITS-1:0] INSTR_PC,
  output logic                    INSTR_VALID,
  input  logic                    INSTR_READY
`ifdef IFETCH_STATS_EN
  ,
  output logic [15:0]             FETCH_COUNT
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t                  state_reg;
  logic [ADDRESS_BITS-1:0] pc_reg;
  logic                    inflight_reg;
  logic [ADDRESS_BITS-1:0] inflight_pc_reg;
  logic [1:0]              count_reg;
  // Slot 0 is always the queue head, so INSTR/INSTR_PC come straight from registers.
  logic [BITS-1:0]         q_data_reg [2];
  logic [ADDRESS_BITS-1:0] q_pc_reg   [2];

  logic       pop;
  logic       branch;
  logic       issue;
  logic       push;
  logic [2:0] occupancy;
  logic [1:0] wr_idx;

  assign ROM_ADDRESS = BRANCH_VALID ? BRANCH_TARGET : pc_reg;
  assign INSTR_VALID = (count_reg != 2'd0);
  assign INSTR       = q_data_reg[0];
  assign INSTR_PC    = q_pc_reg[0];

  always_comb begin
    pop       = INSTR_VALID & INSTR_READY;
    branch    = BRANCH_VALID & (state_reg != BOOT);
    // Slots that will be committed after this cycle, counting the word in flight.
    occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    // A redirect flushes everything, so it never needs the capacity test.
    issue     = (state_reg == RUN) & ~HALT & (branch | (occupancy < 3'd2));
    // The word in flight during a redirect belongs to the old path and is dropped.
    push      = inflight_reg & ~branch;
    wr_idx    = count_reg - {1'b0, pop};
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_reg       <= BOOT;
      pc_reg          <= ADDRESS_BITS'(RESET_VECTOR);
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      count_reg       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_data_reg[i] <= '0;
        q_pc_reg[i]   <= '0;
      end
    end else begin
      case (state_reg)
        BOOT:    state_reg <= RUN;
        RUN:     if (HALT)  state_reg <= HALTED;
        HALTED:  if (!HALT) state_reg <= RUN;
        default: state_reg <= BOOT;
      endcase

      if (issue) begin
        inflight_reg    <= 1'b1;
        inflight_pc_reg <= ROM_ADDRESS;
        pc_reg          <= ROM_ADDRESS + ADDRESS_BITS'(1);
      end else begin
        inflight_reg <= 1'b0;
        // Redirect while halted: remember the target so resume starts there.
        if (branch) pc_reg <= BRANCH_TARGET;
      end

      if (branch) begin
        count_reg <= 2'd0;
      end else begin
        if (pop && count_reg == 2'd2) begin
          q_data_reg[0] <= q_data_reg[1];
          q_pc_reg[0]   <= q_pc_reg[1];
        end
        if (push) begin
          if (wr_idx[0]) begin
            q_data_reg[1] <= ROM_DATA;
            q_pc_reg[1]   <= inflight_pc_reg;
          end else begin
            q_data_reg[0] <= ROM_DATA;
            q_pc_reg[0]   <= inflight_pc_reg;
          end
        end
        count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
      end
    end
  end

`ifdef IFETCH_STATS_EN
  logic [15:0] fetch_count_reg;

  // Counts every accepted word, including one accepted in a redirect cycle.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) fetch_count_reg <= 16'd0;
    else if (pop) fetch_count_reg <= fetch_count_reg + 16'd1;
  end

  assign FETCH_COUNT = fetch_count_reg;
`endif

endmodule
